// File: rtl/touch_scan_ctrl_if.sv
// Bundle of the scan controller's run/sample/averager/result signals.
// The controller connects through the slave modport; the host side uses master.
interface touch_scan_ctrl_if #(
   parameter int NCH = 4,
   parameter int N   = 11
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic          run;
   logic          sample_tick;
   logic [N-1:0]  thresh;
   logic [N-1:0]  avg_in;
   logic [CW-1:0] ch_sel;
   logic          avg_ena;
   logic          avg_rstb;
   logic          result_valid;
   logic [CW-1:0] result_ch;
   logic [N-1:0]  result_avg;
   logic [NCH-1:0] touched;
   logic          busy;

   modport master (
      output run, sample_tick, thresh, avg_in,
      input  ch_sel, avg_ena, avg_rstb, result_valid, result_ch, result_avg, touched, busy
   );

   modport slave (
      input  run, sample_tick, thresh, avg_in,
      output ch_sel, avg_ena, avg_rstb, result_valid, result_ch, result_avg, touched, busy
   );
endinterface

// File: rtl/touch_scan_ctrl.sv
// Time-multiplexes one external averager across NCH touch channels: settle,
// clear, accumulate 2^M samples, capture, then advance to the next channel.
module touch_scan_ctrl #(
   parameter int NCH    = 4,
   parameter int N      = 11,
   parameter int M      = 9,
   parameter int SETTLE = 8
) (
   input logic              cclk,
   input logic              rst,
   touch_scan_ctrl_if.slave bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETTLE  = 3'd1;
   localparam logic [2:0] S_CLEAR   = 3'd2;
   localparam logic [2:0] S_ACCUM   = 3'd3;
   localparam logic [2:0] S_CAPTURE = 3'd4;

   localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [M:0]    WIN_LAST    = {1'b1, {M{1'b0}}};
   localparam logic [CW-1:0] CH_LAST     = CW'(NCH - 1);

   logic [2:0]     r_state;
   logic [2:0]     w_stateNext;
   logic [7:0]     r_settleCnt;
   logic [M:0]     r_sampleCnt;
   logic [CW-1:0]  r_chSel;
   logic           r_avgRstb;
   logic           r_resultValid;
   logic [CW-1:0]  r_resultCh;
   logic [N-1:0]   r_resultAvg;
   logic [NCH-1:0] r_touched;
   logic           w_avgEna;

   assign w_avgEna = (r_state == S_ACCUM) && bus.sample_tick;

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.run) w_stateNext = S_SETTLE;
         end
         S_SETTLE: begin
            if (bus.sample_tick && (r_settleCnt == SETTLE_LAST)) w_stateNext = S_CLEAR;
         end
         S_CLEAR: begin
            w_stateNext = S_ACCUM;
         end
         // The first enabled sample only primes the averager, so the window
         // closes on the pulse that arrives once 2^M have been counted.
         S_ACCUM: begin
            if (w_avgEna && (r_sampleCnt == WIN_LAST)) w_stateNext = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_stateNext = bus.run ? S_SETTLE : S_IDLE;
         end
         default: begin
            w_stateNext = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_settleCnt   <= '0;
         r_sampleCnt   <= '0;
         r_avgRstb     <= 1'b0;
         r_resultValid <= 1'b0;
      end else begin
         r_state       <= w_stateNext;
         r_avgRstb     <= (w_stateNext != S_CLEAR);
         r_resultValid <= (r_state == S_CAPTURE);

         if (r_state != S_SETTLE) begin
            r_settleCnt <= '0;
         end else if (bus.sample_tick) begin
            r_settleCnt <= r_settleCnt + 8'd1;
         end

         if (r_state == S_CLEAR) begin
            r_sampleCnt <= '0;
         end else if (w_avgEna && (r_sampleCnt != WIN_LAST)) begin
            r_sampleCnt <= r_sampleCnt + (M+1)'(1);
         end
      end
   end

   // Channel bookkeeping; the explicit wrap keeps non-power-of-two NCH in range.
   always_ff @(posedge cclk or posedge rst) begin
      if (rst) begin
         r_chSel     <= '0;
         r_resultCh  <= '0;
         r_resultAvg <= '0;
         r_touched   <= '0;
      end else if (r_state == S_CAPTURE) begin
         r_resultAvg        <= bus.avg_in;
         r_resultCh         <= r_chSel;
         r_touched[r_chSel] <= (bus.avg_in >= bus.thresh);
         r_chSel            <= (r_chSel == CH_LAST) ? '0 : r_chSel + CW'(1);
      end
   end

   assign bus.ch_sel       = r_chSel;
   assign bus.avg_ena      = w_avgEna;
   assign bus.avg_rstb     = r_avgRstb;
   assign bus.result_valid = r_resultValid;
   assign bus.result_ch    = r_resultCh;
   assign bus.result_avg   = r_resultAvg;
   assign bus.touched      = r_touched;
   assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Scoreboard bench for touch_scan_ctrl: random tick rates and per-channel raw
// levels, a behavioural averager, and a second NCH=3 instance for wrap checks.
module tb_touch_scan_ctrl;
   localparam int NCH    = 4;
   localparam int N      = 11;
   localparam int M      = 9;
   localparam int SETTLE = 8;
   localparam int WIN    = 1 << M;

   typedef struct {
      int ch;
      int avg;
      int touched;
   } exp_t;

   logic cclk = 1'b0;
   logic rst  = 1'b1;

   int tests = 0;
   int fails = 0;

   exp_t           sb[$];
   logic [N-1:0]   rawTab [NCH];
   logic [NCH-1:0] touchedModel;
   int             chModel    = 0;
   int             tickMode   = 2;
   int             enaCount   = 0;
   int             settleTicks = 0;
   int             enaOutside = 0;
   bit             inWindow   = 1'b0;
   int             exp3       = 0;
   int             bad3       = 0;

   always #5 cclk = ~cclk;

   touch_scan_ctrl_if #(.NCH(NCH), .N(N)) bus ();
   touch_scan_ctrl #(.NCH(NCH), .N(N), .M(M), .SETTLE(SETTLE)) dut (
      .cclk (cclk),
      .rst  (rst),
      .bus  (bus)
   );

   touch_scan_ctrl_if #(.NCH(3), .N(N)) bus3 ();
   touch_scan_ctrl #(.NCH(3), .N(N), .M(2), .SETTLE(1)) dut3 (
      .cclk (cclk),
      .rst  (rst),
      .bus  (bus3)
   );

   assign bus3.run         = 1'b1;
   assign bus3.sample_tick = bus.sample_tick;
   assign bus3.thresh      = '0;
   assign bus3.avg_in      = N'(5);

   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic failNow(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: event occurred or bound expired, expected otherwise", name);
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "_busy"},         int'(bus.busy), 0);
      checkOutput({name, "_ch_sel"},       int'(bus.ch_sel), 0);
      checkOutput({name, "_avg_ena"},      int'(bus.avg_ena), 0);
      checkOutput({name, "_avg_rstb"},     int'(bus.avg_rstb), 0);
      checkOutput({name, "_result_valid"}, int'(bus.result_valid), 0);
      checkOutput({name, "_result_ch"},    int'(bus.result_ch), 0);
      checkOutput({name, "_result_avg"},   int'(bus.result_avg), 0);
      checkOutput({name, "_touched"},      int'(bus.touched), 0);
   endtask

   task automatic randomRaws();
      for (int c = 0; c < NCH; c++) rawTab[c] = N'($urandom_range(2047, 0));
   endtask

   task automatic doReset(input string name);
      @(posedge cclk);
      #2;
      rst     = 1'b1;
      bus.run = 1'b0;
      #1;
      checkResetOutputs(name);
      sb.delete();
      touchedModel = '0;
      chModel      = 0;
      repeat (2) @(posedge cclk);
      #3;
      rst = 1'b0;
      @(posedge cclk);
      #1;
      checkOutput({name, "_avg_rstb_release"}, int'(bus.avg_rstb), 1);
   endtask

   // Scan k channels: expected results are queued up front, run is dropped
   // somewhere inside the last channel's window.
   task automatic applyStimulus(input int k, input int th);
      int   budget;
      int   cyc;
      int   hold;
      exp_t e;
      bus.thresh = N'(th);
      for (int i = 0; i < k; i++) begin
         touchedModel[chModel] = (int'(rawTab[chModel]) >= th);
         e.ch      = chModel;
         e.avg     = int'(rawTab[chModel]);
         e.touched = int'(touchedModel);
         sb.push_back(e);
         chModel = (chModel + 1) % NCH;
      end
      budget  = k * 3000 + 500;
      cyc     = 0;
      bus.run = 1'b1;
      while (sb.size() > 1 && cyc < budget) begin
         @(posedge cclk);
         cyc++;
      end
      hold = $urandom_range(400, 60);
      repeat (hold) @(posedge cclk);
      #1;
      bus.run = 1'b0;
      while ((sb.size() > 0 || bus.busy) && cyc < budget) begin
         @(posedge cclk);
         cyc++;
      end
      if (cyc >= budget) failNow("session_timeout");
      @(negedge cclk);
      checkOutput("idle_busy", int'(bus.busy), 0);
      checkOutput("idle_ch_sel", int'(bus.ch_sel), chModel);
   endtask

   task automatic resetMidWindow();
      int cyc;
      cyc = 0;
      randomRaws();
      bus.thresh = N'($urandom_range(2047, 0));
      bus.run    = 1'b1;
      while (!(inWindow && enaCount >= 300) && cyc < 5000) begin
         @(negedge cclk);
         cyc++;
      end
      if (cyc >= 5000) failNow("mid_window_wait");
      doReset("mid_window_reset");
   endtask

   initial begin
      int phase;
      phase           = 0;
      bus.sample_tick = 1'b0;
      forever begin
         @(posedge cclk);
         #1;
         case (tickMode)
            1:       bus.sample_tick = 1'b1;
            2:       bus.sample_tick = (phase == 0);
            default: bus.sample_tick = 1'($urandom_range(1, 0));
         endcase
         phase = (phase + 1) % 4;
      end
   end

   // Averager: first enable primes the pipe, each later one adds the primed
   // sample, so after 2^M+1 enables the output is the mean of samples 1..2^M.
   initial begin
      logic [N+M-1:0] acc;
      logic [N-1:0]   pipe;
      logic [N-1:0]   rawS;
      bit             primed;
      bit             enaS;
      bit             rstbS;
      acc        = '0;
      pipe       = '0;
      primed     = 1'b0;
      bus.avg_in = '0;
      forever begin
         @(negedge cclk);
         enaS  = bus.avg_ena;
         rstbS = bus.avg_rstb;
         rawS  = rawTab[bus.ch_sel];
         @(posedge cclk);
         #1;
         if (!rstbS) begin
            acc    = '0;
            primed = 1'b0;
         end else if (enaS) begin
            if (primed) acc = acc + (N+M)'(pipe);
            pipe   = rawS;
            primed = 1'b1;
         end
         bus.avg_in = acc[N+M-1:M];
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge cclk);
         if (rst) begin
            enaCount    = 0;
            settleTicks = 0;
            inWindow    = 1'b0;
         end else begin
            if (!bus.avg_rstb && bus.busy) begin
               checkOutput("settle_ticks", settleTicks, SETTLE);
               inWindow = 1'b1;
               enaCount = bus.avg_ena ? 1 : 0;
            end else if (inWindow) begin
               enaCount += int'(bus.avg_ena);
            end else begin
               if (bus.avg_ena) enaOutside++;
               if (bus.busy && bus.sample_tick) settleTicks++;
            end
            if (bus.result_valid) begin
               checkOutput("ena_per_window", enaCount, WIN + 1);
               if (sb.size() == 0) begin
                  failNow("unexpected_result_valid");
               end else begin
                  e = sb.pop_front();
                  checkOutput("result_ch", int'(bus.result_ch), e.ch);
                  checkOutput("result_avg", int'(bus.result_avg), e.avg);
                  checkOutput("touched", int'(bus.touched), e.touched);
               end
               inWindow    = 1'b0;
               settleTicks = (bus.busy && bus.sample_tick) ? 1 : 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge cclk);
         if (rst) begin
            exp3 = 0;
         end else begin
            if (int'(bus3.ch_sel) > 2) bad3++;
            if (bus3.result_valid) begin
               checkOutput("nch3_result_ch", int'(bus3.result_ch), exp3);
               exp3 = (exp3 + 1) % 3;
               checkOutput("nch3_ch_sel", int'(bus3.ch_sel), exp3);
            end
         end
      end
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus.run      = 1'b0;
      bus.thresh   = '0;
      touchedModel = '0;
      for (int c = 0; c < NCH; c++) rawTab[c] = '0;
      repeat (3) @(posedge cclk);
      doReset("por");

      tickMode  = 2;
      randomRaws();
      rawTab[0] = N'(1000);
      applyStimulus(1, $urandom_range(2047, 0));

      doReset("idle_reset");

      tickMode  = 0;
      rawTab[0] = N'(100);
      rawTab[1] = N'(2000);
      rawTab[2] = N'(100);
      rawTab[3] = N'(2000);
      applyStimulus(5, 1000);
      checkOutput("touched_first_pass", int'(bus.touched), 'b1010);

      applyStimulus(1, 1000);

      tickMode = 1;
      randomRaws();
      applyStimulus(2, $urandom_range(2047, 0));

      for (int i = 0; i < 3; i++) begin
         tickMode = $urandom_range(2, 0);
         randomRaws();
         applyStimulus($urandom_range(3, 1), $urandom_range(2047, 0));
      end

      tickMode = 0;
      resetMidWindow();
      randomRaws();
      applyStimulus(2, $urandom_range(2047, 0));

      checkOutput("ena_outside_window", enaOutside, 0);
      checkOutput("nch3_ch_sel_range", bad3, 0);
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/touch_scan_ctrl.md
TOUCH_SCAN_CTRL -- requirements
Module: touch_scan_ctrl

Interface
REQ-001 Parameter NCH, default 4: number of touch channels sharing one averager.
REQ-002 Parameter N, default 11: averaged-result width.
REQ-003 Parameter M, default 9: log2 of samples per averaging window (2^M samples).
REQ-004 Parameter SETTLE, default 8: sample ticks discarded after each channel switch, range 1..255.
REQ-005 cclk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 run  in  1  level; 1 = scan channels continuously, 0 = stop after current channel.
REQ-008 sample_tick  in  1  one-cycle strobe marking a new raw sample.
REQ-009 thresh  in  N  touch threshold, sampled at CAPTURE.
REQ-010 avg_in  in  N  averager result.
REQ-011 ch_sel  out  clog2(NCH)  analog mux / channel select.
REQ-012 avg_ena  out  1  sample-enable pulse to averager.
REQ-013 avg_rstb  out  1  active-low synchronous clear to averager.
REQ-014 result_valid  out  1  one-cycle pulse, new result available.
REQ-015 result_ch  out  clog2(NCH)  channel of current result.
REQ-016 result_avg  out  N  captured average.
REQ-017 touched  out  NCH  per-channel touch flags, bit i = last result of channel i >= thresh.
REQ-018 busy  out  1  1 in any state other than IDLE.

Function
REQ-019 States: IDLE, SETTLE, CLEAR, ACCUM, CAPTURE; encoding free.
REQ-020 IDLE: when run=1, go to SETTLE, ch_sel unchanged, settle counter cleared.
REQ-021 SETTLE: count sample_tick pulses; avg_ena held 0; after SETTLE ticks go to CLEAR.
REQ-022 CLEAR: avg_rstb=0 for exactly one cycle, sample counter cleared, next state ACCUM.
REQ-023 ACCUM: avg_ena = sample_tick (combinational, same cycle); count enabled samples.
REQ-024 ACCUM exits to CAPTURE in the cycle after the (2^M+1)-th avg_ena pulse (first pulse primes the averager; result of pulses 1..2^M appears after pulse 2^M+1).
REQ-025 Sample counter width M+1 bits, shall not wrap within a window.
REQ-026 CAPTURE (one cycle): result_avg<=avg_in, result_ch<=ch_sel, touched[ch_sel]<=(avg_in>=thresh), unsigned compare; result_valid=1 next cycle for one cycle.
REQ-027 After CAPTURE: ch_sel<=ch_sel+1, wrapping NCH-1 -> 0 (also for non-power-of-two NCH); then SETTLE if run=1, else IDLE.
REQ-028 run deasserted mid-window does not abort; current channel completes and reports.
REQ-029 sample_tick in SETTLE, CLEAR or CAPTURE shall never produce avg_ena.
REQ-030 sample_tick coincident with the CLEAR cycle is dropped (not counted anywhere).
REQ-031 avg_rstb=1 in every state except CLEAR; avg_ena=0 outside ACCUM.
REQ-032 touched bits for other channels hold their values; only the captured channel's bit updates.

Reset
REQ-033 On rst=1, immediately: state IDLE, ch_sel=0, counters=0, avg_ena=0, avg_rstb=0, result_valid=0, result_ch=0, result_avg=0, touched=0, busy=0.
REQ-034 After rst falls, avg_rstb returns to 1 on the first cclk edge; reset mid-window discards partial work, no result_valid.

Verification
REQ-035 rst pulse, run=1, sample_tick every 4 cycles, averager model fed constant raw=1000 -> 8 ticks with no avg_ena, one CLEAR cycle, 513 avg_ena pulses, result_valid with result_ch=0, result_avg=1000.
REQ-036 NCH=4, run held 1, per-channel raw 100/2000/100/2000, thresh=1000 -> results in order ch 0,1,2,3,0; touched=4'b1010 after first pass.
REQ-037 run dropped during channel 1 ACCUM -> channel 1 result reported, then IDLE, busy=0, ch_sel=2; run=1 resumes at channel 2.
REQ-038 sample_tick asserted every cycle (max rate) -> exactly 513 avg_ena in ACCUM, tick coincident with CLEAR not counted, correct average.
REQ-039 rst asserted at sample 300 of a window -> outputs reset asynchronously same cycle, no result_valid, next scan starts at channel 0 with full SETTLE.
REQ-040 NCH=3 -> ch_sel sequence 0,1,2,0, never 3.
